// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared encodings and helpers for the pipeline hazard controller
package hazard_ctrl_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_IVT = 2'b10;
  localparam logic [1:0] PC_RST = 2'b11;

  localparam int REG_W = 3;
  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    RST,
    RUN,
    DRAIN,
    PUSH,
    VECTOR
  } state_e;

  function automatic logic reg_hit(input logic use_i,
                                   input logic [REG_W-1:0] src,
                                   input logic [REG_W-1:0] dst);
    return use_i & (src == dst);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use comparator between decode and execute
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rdst,
  input  logic [REG_W-1:0] id_rsrc1,
  input  logic [REG_W-1:0] id_rsrc2,
  input  logic             id_use1,
  input  logic             id_use2,
  output logic             load_use
);

  assign load_use = ex_mem_read &
                    (reg_hit(id_use1, id_rsrc1, ex_rdst) |
                     reg_hit(id_use2, id_rsrc2, ex_rdst));

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline sequencing: load-use stalls, branch flushes, reset and interrupt entry
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int PC_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             intr,
  input  logic [PC_W-1:0]  fetch_pc,
  input  logic [REG_W-1:0] id_rsrc1,
  input  logic [REG_W-1:0] id_rsrc2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rdst,
  input  logic             ex_branch,
  output logic [1:0]       pc_select,
  output logic             fetch_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             de_en,
  output logic             de_flush,
  output logic             push_pc,
  output logic [PC_W-1:0]  ret_pc,
  output logic             int_busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic             rearm_q, rearm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  ret_pc_q, ret_pc_d;
  logic             load_use;

  hazard_detect u_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rdst     (ex_rdst),
    .id_rsrc1    (id_rsrc1),
    .id_rsrc2    (id_rsrc2),
    .id_use1     (id_use1),
    .id_use2     (id_use2),
    .load_use    (load_use)
  );

  // rearm holds an intr seen during DRAIN so the clear on entering PUSH cannot drop it
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q | intr;
    rearm_d  = rearm_q;
    cnt_d    = cnt_q;
    ret_pc_d = ret_pc_q;
    case (state_q)
      RST: state_d = RUN;
      RUN: begin
        if (pend_q && !ex_branch && !load_use) begin
          ret_pc_d = fetch_pc;
          cnt_d    = '0;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (intr) rearm_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = PUSH;
          pend_d  = intr | rearm_q;
          rearm_d = 1'b0;
        end
      end
      PUSH:    state_d = VECTOR;
      VECTOR:  state_d = RUN;
      default: state_d = RST;
    endcase
  end

  always_comb begin
    pc_select = PC_SEQ;
    fetch_en  = 1'b1;
    fd_en     = 1'b1;
    fd_flush  = 1'b0;
    de_en     = 1'b1;
    de_flush  = 1'b0;
    push_pc   = 1'b0;
    int_busy  = 1'b0;
    case (state_q)
      RST: begin
        pc_select = PC_RST;
        fd_flush  = 1'b1;
        de_flush  = 1'b1;
      end
      RUN: begin
        if (ex_branch) begin
          pc_select = PC_BR;
          fd_flush  = 1'b1;
          de_flush  = 1'b1;
        end else if (load_use) begin
          fetch_en = 1'b0;
          fd_en    = 1'b0;
          de_flush = 1'b1;
        end
      end
      DRAIN: begin
        fetch_en = 1'b0;
        fd_flush = 1'b1;
        int_busy = 1'b1;
      end
      PUSH: begin
        fetch_en = 1'b0;
        fd_flush = 1'b1;
        int_busy = 1'b1;
        push_pc  = 1'b1;
      end
      VECTOR: begin
        pc_select = PC_IVT;
        fd_flush  = 1'b1;
        int_busy  = 1'b1;
      end
      default: begin
        pc_select = PC_RST;
        fd_flush  = 1'b1;
        de_flush  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RST;
      pend_q   <= 1'b0;
      rearm_q  <= 1'b0;
      cnt_q    <= '0;
      ret_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      rearm_q  <= rearm_d;
      cnt_q    <= cnt_d;
      ret_pc_q <= ret_pc_d;
    end
  end

  assign ret_pc = ret_pc_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        intr;
  logic [31:0] fetch_pc;
  logic [2:0]  id_rsrc1, id_rsrc2, ex_rdst;
  logic        id_use1, id_use2, ex_mem_read, ex_branch;
  logic [1:0]  pc_select;
  logic        fetch_en, fd_en, fd_flush, de_en, de_flush, push_pc, int_busy;
  logic [31:0] ret_pc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.DRAIN_CYCLES(3), .PC_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .intr        (intr),
    .fetch_pc    (fetch_pc),
    .id_rsrc1    (id_rsrc1),
    .id_rsrc2    (id_rsrc2),
    .id_use1     (id_use1),
    .id_use2     (id_use2),
    .ex_mem_read (ex_mem_read),
    .ex_rdst     (ex_rdst),
    .ex_branch   (ex_branch),
    .pc_select   (pc_select),
    .fetch_en    (fetch_en),
    .fd_en       (fd_en),
    .fd_flush    (fd_flush),
    .de_en       (de_en),
    .de_flush    (de_flush),
    .push_pc     (push_pc),
    .ret_pc      (ret_pc),
    .int_busy    (int_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    intr = 0; id_rsrc1 = 0; id_rsrc2 = 0; id_use1 = 0; id_use2 = 0;
    ex_mem_read = 0; ex_rdst = 0; ex_branch = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; fetch_pc = 32'h0;
    clear_inputs();

    repeat (3) tick();
    #1;
    chk("rst_pc_select", pc_select, 2'b11);
    chk("rst_fetch_en", fetch_en, 1);
    chk("rst_flushes", {fd_flush, de_flush, fd_en, de_en}, 4'b1111);
    chk("rst_push_busy", {push_pc, int_busy}, 2'b00);
    chk("rst_ret_pc", ret_pc, 32'h0);

    rst = 1;
    #1;
    chk("release_pc_select_held", pc_select, 2'b11);
    tick(); #1;
    chk("run_pc_select", pc_select, 2'b00);
    chk("run_flushes", {fd_flush, de_flush}, 2'b00);
    chk("run_enables", {fetch_en, fd_en, de_en}, 3'b111);

    ex_mem_read = 1; ex_rdst = 3; id_rsrc2 = 3; id_use2 = 1;
    #1;
    chk("lu_stall", {fetch_en, fd_en, de_flush, de_en, fd_flush}, 5'b00110);
    chk("lu_pc_select", pc_select, 2'b00);
    tick();
    ex_mem_read = 0; #1;
    chk("lu_released", {fetch_en, fd_en, de_flush}, 3'b110);
    ex_mem_read = 1; id_use2 = 0; #1;
    chk("lu_unused_src", {fetch_en, fd_en, de_flush}, 3'b110);
    id_rsrc1 = 3; id_use1 = 1; #1;
    chk("lu_src1", {fetch_en, fd_en, de_flush}, 3'b001);
    ex_rdst = 4; #1;
    chk("lu_diff_reg", {fetch_en, fd_en, de_flush}, 3'b110);

    ex_rdst = 3; ex_branch = 1; #1;
    chk("br_pc_select", pc_select, 2'b01);
    chk("br_over_lu", {fetch_en, fd_en, fd_flush, de_flush}, 4'b1111);
    tick();
    clear_inputs();

    fetch_pc = 32'h40;
    tick(); intr = 1; #1;
    chk("c10_busy", int_busy, 0);
    tick(); intr = 0; #1;
    chk("c11_accept", {int_busy, fetch_en, pc_select}, 4'b0100);
    tick(); fetch_pc = 32'h44; #1;
    chk("c12_drain", {int_busy, fetch_en, fd_flush, push_pc}, 4'b1010);
    chk("c12_ret_pc", ret_pc, 32'h40);
    tick(); intr = 1; #1;
    chk("c13_drain", {int_busy, push_pc}, 2'b10);
    tick(); intr = 0; #1;
    chk("c14_drain", {int_busy, push_pc}, 2'b10);
    tick(); #1;
    chk("c15_push", {push_pc, fetch_en, fd_flush, int_busy}, 4'b1011);
    tick(); fetch_pc = 32'h80; #1;
    chk("c16_vector", {pc_select, fetch_en, fd_flush, int_busy, push_pc}, 6'b101110);
    chk("c16_ret_pc", ret_pc, 32'h40);
    tick(); #1;
    chk("c17_accept2", {int_busy, pc_select}, 3'b000);
    tick(); #1;
    chk("c18_drain2", int_busy, 1);
    chk("c18_ret_pc", ret_pc, 32'h80);
    tick(); tick(); tick(); #1;
    chk("c21_push2", push_pc, 1);
    tick(); #1;
    chk("c22_vector2", pc_select, 2'b10);
    tick(); tick(); #1;
    chk("c24_idle", {int_busy, push_pc}, 2'b00);

    tick(); intr = 1;
    tick(); intr = 0;
    tick(); tick(); intr = 1;
    tick(); intr = 0;
    tick(); #1;
    chk("abort_in_push", push_pc, 1);
    rst = 0; #1;
    chk("abort_push_drop", push_pc, 0);
    chk("abort_rst_outs", {pc_select, fetch_en, fd_flush, de_flush, int_busy}, 6'b111110);
    chk("abort_ret_pc", ret_pc, 32'h0);
    tick(); tick();
    rst = 1;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick(); #1;
      chk("abort_no_pend", {int_busy, push_pc, pc_select}, 4'b0000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
